// File: rtl/ov7670_capture_pkg.sv
// Shared definitions for the OV7670 capture path: FSM states, RGB565 layout
// and default QVGA geometry.
package ov7670_capture_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    BLANK     = 2'd1,
    CAPTURE   = 2'd2
  } cap_state_e;

  localparam int DEFAULT_IMG_W = 320;
  localparam int DEFAULT_IMG_H = 240;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  // The camera sends R5 G3 first, then G3 B5; green straddles the byte boundary.
  function automatic logic [15:0] rgb565_pack(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] px;
    px = '0;
    px[RGB_R_MSB:RGB_R_LSB] = hi[7:3];
    px[RGB_G_MSB:RGB_G_LSB] = {hi[2:0], lo[7:5]};
    px[RGB_B_MSB:RGB_B_LSB] = lo[4:0];
    return px;
  endfunction

endpackage

// File: rtl/ov7670_capture_edge_detect.sv
// Two-flop synchroniser-style register with combinational rise/fall flags;
// level is the first-stage copy so decisions line up with the data register.
module ov7670_capture_edge_detect (
  input  logic ov_pclk,
  input  logic reset_n,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall
);

  logic d1;
  logic d2;

  always_ff @(posedge ov_pclk or negedge reset_n) begin
    if (!reset_n) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= sig;
      d2 <= d1;
    end
  end

  assign level = d1;
  assign rise  = d1 & ~d2;
  assign fall  = ~d1 & d2;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 byte-stream deserialiser producing frame buffer writes,
// frame completion pulses and line-length error reporting.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int IMG_W  = DEFAULT_IMG_W,
  parameter int IMG_H  = DEFAULT_IMG_H,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              ov_pclk,
  input  logic              reset_n,
  input  logic              ov_vsync,
  input  logic              ov_href,
  input  logic [7:0]        ov_data,
  input  logic              en,
  output logic              WE,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              line_err,
  output logic              busy
);

  localparam int NPIX       = IMG_W * IMG_H;
  localparam int CNT_W      = $clog2(NPIX + 1);
  localparam int LINE_BYTES = 2 * IMG_W;
  localparam int BC_W       = $clog2(LINE_BYTES + 1);

  localparam logic [CNT_W-1:0] NPIX_C = CNT_W'(NPIX);
  localparam logic [BC_W-1:0]  LINE_C = BC_W'(LINE_BYTES);
  localparam logic [BC_W-1:0]  BC_MAX = '1;

  cap_state_e       state;
  logic [7:0]       data_d1;
  logic [7:0]       hi_byte;
  logic             phase;
  logic [CNT_W-1:0] addr_cnt;
  logic [BC_W-1:0]  byte_cnt;

  logic vs_lvl, vs_rise, vs_fall;
  logic hr_lvl, hr_rise, hr_fall;

  ov7670_capture_edge_detect u_vsync_edge (
    .ov_pclk (ov_pclk),
    .reset_n (reset_n),
    .sig     (ov_vsync),
    .level   (vs_lvl),
    .rise    (vs_rise),
    .fall    (vs_fall)
  );

  ov7670_capture_edge_detect u_href_edge (
    .ov_pclk (ov_pclk),
    .reset_n (reset_n),
    .sig     (ov_href),
    .level   (hr_lvl),
    .rise    (hr_rise),
    .fall    (hr_fall)
  );

  always_ff @(posedge ov_pclk or negedge reset_n) begin
    if (!reset_n) begin
      data_d1 <= '0;
    end else begin
      data_d1 <= ov_data;
    end
  end

  // The count restarts at 1 on href rise because d1 already holds the first byte.
  always_ff @(posedge ov_pclk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= '0;
    end else if (hr_rise) begin
      byte_cnt <= BC_W'(1);
    end else if (hr_lvl && byte_cnt != BC_MAX) begin
      byte_cnt <= byte_cnt + BC_W'(1);
    end
  end

  always_ff @(posedge ov_pclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SYNC_WAIT;
      phase      <= 1'b0;
      hi_byte    <= '0;
      addr_cnt   <= '0;
      WE         <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      line_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      WE         <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        SYNC_WAIT: begin
          if (vs_lvl) state <= BLANK;
        end
        BLANK: begin
          if (vs_fall && en) begin
            state    <= CAPTURE;
            busy     <= 1'b1;
            addr_cnt <= '0;
            phase    <= 1'b0;
            line_err <= 1'b0;
          end
        end
        CAPTURE: begin
          if (hr_lvl) begin
            if (!phase) begin
              hi_byte <= data_d1;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              // Past the last pixel the counter parks so pixel 0 is never overwritten.
              if (addr_cnt < NPIX_C) begin
                WE       <= 1'b1;
                wAddr    <= ADDR_W'(addr_cnt);
                wData    <= rgb565_pack(hi_byte, data_d1);
                addr_cnt <= addr_cnt + CNT_W'(1);
              end
            end
          end
          if (hr_fall) begin
            phase <= 1'b0;
            if (byte_cnt != LINE_C) line_err <= 1'b1;
          end
          if (vs_rise) begin
            state      <= BLANK;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
          end
        end
        default: begin
          state <= SYNC_WAIT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture on a 4x2 image: expected writes are
// queued as bytes are driven and popped whenever the DUT strobes WE.
module tb_ov7670_capture;

  localparam int IMG_W      = 4;
  localparam int IMG_H      = 2;
  localparam int ADDR_W     = 3;
  localparam int NPIX       = IMG_W * IMG_H;
  localparam int LINE_BYTES = 2 * IMG_W;

  logic              ov_pclk = 1'b0;
  logic              reset_n;
  logic              ov_vsync;
  logic              ov_href;
  logic [7:0]        ov_data;
  logic              en;
  logic              WE;
  logic [ADDR_W-1:0] wAddr;
  logic [15:0]       wData;
  logic              frame_done;
  logic [7:0]        frame_cnt;
  logic              line_err;
  logic              busy;

  int total = 0;
  int bad = 0;
  int doneCount = 0;
  int weCount = 0;
  bit prevDone = 1'b0;
  int expCnt = 0;
  int expDone = 0;
  bit lastErr = 1'b0;

  logic [ADDR_W-1:0] expAddrQ[$];
  logic [15:0]       expDataQ[$];

  ov7670_capture #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) dut (
    .ov_pclk    (ov_pclk),
    .reset_n    (reset_n),
    .ov_vsync   (ov_vsync),
    .ov_href    (ov_href),
    .ov_data    (ov_data),
    .en         (en),
    .WE         (WE),
    .wAddr      (wAddr),
    .wData      (wData),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .line_err   (line_err),
    .busy       (busy)
  );

  always #5 ov_pclk = ~ov_pclk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge ov_pclk);
  endtask

  // Outputs are sampled on the falling edge, half a cycle clear of the active edge.
  always @(negedge ov_pclk) begin
    if (prevDone) checkOutput("done_width", 32'(frame_done), 32'd0);
    prevDone <= frame_done;
    if (frame_done) doneCount <= doneCount + 1;
    if (WE) begin
      weCount <= weCount + 1;
      if (expAddrQ.size() == 0) begin
        checkOutput("we_unexpected", 32'(WE), 32'd0);
      end else begin
        checkOutput("waddr", 32'(wAddr), 32'(expAddrQ[0]));
        checkOutput("wdata", 32'(wData), 32'(expDataQ[0]));
        void'(expAddrQ.pop_front());
        void'(expDataQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input int nLines, input int badLine, input int badLen, input bit enVal);
    int val;
    int len;
    int expA;
    int weStart;
    bit expErr;
    logic [7:0] hi;
    val = 0;
    expA = 0;
    expErr = 1'b0;
    hi = '0;
    en = enVal;
    tick(2);
    ov_vsync = 1'b0;
    tick(4);
    checkOutput("busy_mid", 32'(busy), 32'(enVal));
    if (enVal) checkOutput("line_err_clr", 32'(line_err), 32'd0);
    weStart = weCount;
    for (int l = 0; l < nLines; l++) begin
      len = (l == badLine) ? badLen : LINE_BYTES;
      if (len != LINE_BYTES) expErr = 1'b1;
      for (int b = 0; b < len; b++) begin
        ov_href = 1'b1;
        ov_data = 8'(val);
        if ((b % 2) == 0) begin
          hi = 8'(val);
        end else if (enVal && expA < NPIX) begin
          expAddrQ.push_back(ADDR_W'(expA));
          expDataQ.push_back({hi, 8'(val)});
          expA++;
        end
        val++;
        tick(1);
      end
      ov_href = 1'b0;
      ov_data = 8'h00;
      tick(3);
    end
    ov_vsync = 1'b1;
    if (enVal) begin
      expCnt = (expCnt + 1) % 256;
      expDone++;
      lastErr = expErr;
    end
    tick(6);
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(expCnt));
    checkOutput("line_err", 32'(line_err), 32'(lastErr));
    checkOutput("done_count", 32'(doneCount), 32'(expDone));
    checkOutput("sb_drained", 32'(expAddrQ.size()), 32'd0);
    checkOutput("frame_writes", 32'(weCount - weStart), 32'(expA));
    checkOutput("busy_blank", 32'(busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneBefore;
    reset_n  = 1'b0;
    ov_vsync = 1'b1;
    ov_href  = 1'b0;
    ov_data  = 8'h00;
    en       = 1'b1;
    tick(3);
    checkOutput("rst_we", 32'(WE), 32'd0);
    checkOutput("rst_waddr", 32'(wAddr), 32'd0);
    checkOutput("rst_wdata", 32'(wData), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    checkOutput("rst_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_err", 32'(line_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick(4);

    $display("[TB] basic frame");
    applyStimulus(2, -1, 0, 1'b1);
    $display("[TB] short line");
    applyStimulus(2, 0, 7, 1'b1);
    applyStimulus(2, -1, 0, 1'b1);
    $display("[TB] extra line overflow");
    applyStimulus(3, -1, 0, 1'b1);
    $display("[TB] capture disabled then resumed");
    applyStimulus(2, -1, 0, 1'b0);
    applyStimulus(2, -1, 0, 1'b1);

    $display("[TB] reset mid-frame");
    en = 1'b1;
    tick(2);
    ov_vsync = 1'b0;
    tick(4);
    checkOutput("busy_pre_rst", 32'(busy), 32'd1);
    ov_href = 1'b1;
    ov_data = 8'hA5;
    tick(1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_cnt", 32'(frame_cnt), 32'd0);
    expCnt = 0;
    lastErr = 1'b0;
    tick(2);
    reset_n = 1'b1;
    for (int b = 0; b < 2 * LINE_BYTES; b++) begin
      ov_href = (b % 10) < 8;
      ov_data = 8'(8'h40 + b);
      tick(1);
    end
    ov_href = 1'b0;
    tick(3);
    checkOutput("busy_resync", 32'(busy), 32'd0);
    ov_vsync = 1'b1;
    tick(4);
    applyStimulus(2, -1, 0, 1'b1);

    $display("[TB] 256 frames");
    doneBefore = doneCount;
    for (int f = 0; f < 256; f++) begin
      applyStimulus(1, -1, 0, 1'b1);
    end
    checkOutput("wrap_done", 32'(doneCount - doneBefore), 32'd256);
    checkOutput("wrap_cnt", 32'(frame_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Upstream feeder of the frame buffer write port, clocked entirely in the camera pixel-clock domain.
- Deserialises the OV7670 8-bit RGB565 byte stream (QVGA, high byte first) into 16-bit pixels.
- Generates a linear write address and write strobe.
- Reports frame completion and line-length errors to the control logic.

Parameters:
- IMG_W, 320, active pixels per line.
- IMG_H, 240, active lines per frame.
- ADDR_W, $clog2(IMG_W*IMG_H), write address width; must match frame buffer address width.

Ports:
- ov_pclk  in  1  camera pixel clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ov_vsync  in  1  camera vsync; high = vertical blanking.
- ov_href  in  1  camera href; high = active line bytes.
- ov_data  in  8  camera data byte.
- en  in  1  capture enable, sampled only at frame start.
- WE  out  1  frame buffer write enable, one-cycle pulse per pixel.
- wAddr  out  ADDR_W  pixel address, row*IMG_W+col.
- wData  out  16  RGB565 pixel, {high byte, low byte}.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- frame_cnt  out  8  captured-frame counter, wraps 255->0.
- line_err  out  1  sticky flag: some line in the current/last frame had a byte count != 2*IMG_W.
- busy  out  1  high while in CAPTURE.

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM is in SYNC_WAIT.
  - Byte phase is 0.
  - Address counter is 0.
- Input stage:
  - ov_vsync, ov_href and ov_data are registered once (d1).
  - All decisions use d1 and a second-stage copy of vsync/href for edge detection.
- FSM:
  - SYNC_WAIT: wait for d1 vsync high. This discards the partial frame in progress at reset. Go to BLANK.
  - BLANK: on vsync falling edge:
    - If en=1: go to CAPTURE; clear address counter, phase and line_err.
    - Otherwise stay in BLANK.
  - CAPTURE: on vsync rising edge, go to BLANK and pulse frame_done for 1 cycle. frame_cnt increments in the same cycle.
- Pixel assembly, applied only in CAPTURE while d1 href=1:
  - Phase 0: latch the high byte; phase becomes 1.
  - Phase 1: form the pixel; phase becomes 0.
  - Outputs are registered. WE=1 with wData/wAddr valid in the cycle after the edge where d1 holds the low byte. Total latency is 2 ov_pclk edges from the low byte at the pins to WE visible.
  - wAddr of that write is the current address counter. The counter increments after each write.
- Line boundaries:
  - On href falling edge, phase is forced to 0. An odd trailing byte is dropped.
  - line_err is set if the line's byte count != 2*IMG_W. Per-line byte counter width is $clog2(2*IMG_W+1), saturating.
- Overflow: once the address counter reaches IMG_W*IMG_H, WE is suppressed and the counter holds for the rest of the frame. No wrap, no overwrite of pixel 0.
- Simultaneous events: a vsync rising edge in the same cycle as a pixel completion lets that write complete; frame_done asserts in the same cycle.
- en deasserted mid-frame has no effect until the next frame start.
- Reset mid-frame:
  - Outputs clear immediately (asynchronous).
  - On release, the FSM re-enters SYNC_WAIT, so no partial frame is ever written with address 0 misaligned.
- busy = (state == CAPTURE).

Decomposition:
- Shared package holds:
  - FSM state encoding: SYNC_WAIT, BLANK, CAPTURE.
  - RGB565 field positions (R[15:11], G[10:5], B[4:0]).
  - Default IMG_W/IMG_H.
- Sub-module: edge_detect, shared for vsync/href rise/fall. Two-flop register plus combinational rise/fall outputs.
- All other logic lives in one module.

Test Plan:
- Run with IMG_W=4, IMG_H=2. Reset, then one blank vsync, then a frame of 2 lines × 8 bytes 0x00..0x0F -> WE pulses at addresses 0..7 with wData 0x0001, 0x0203 … 0x0E0F; exactly one frame_done; frame_cnt=1; line_err=0.
- Release reset during an active frame (vsync low, href toggling) -> no WE until the next full frame; the first write lands at wAddr=0.
- Line with 7 bytes -> 3 writes for that line, last byte dropped, line_err=1. line_err clears at the next frame start.
- Frame with 3 lines (IMG_H=2) -> writes only at addresses 0..7; no WE during the third line; frame_done still pulses once.
- en=0 at the vsync falling edge -> zero WE for that frame, busy=0, frame_cnt unchanged. en=1 at the next frame -> capture resumes.
- 256 consecutive captured frames -> frame_cnt wraps to 0; frame_done pulses 256 times, each exactly 1 cycle.
